// File: rtl/enemy_wave_scheduler_pkg.sv
// Shared definitions for the enemy wave scheduler.
// Contents:
//   state_t  - scheduler state encoding (IDLE, SPAWN, ACTIVE, INTERMIT)
//   KILL_W   - width of the kill counter
//   WAVE_W   - width of the wave counter
//   TIMER_W  - width of the shared frame timer
//   KILL_MAX - saturation value of the kill counter
package enemy_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPAWN    = 2'd1,
    ACTIVE   = 2'd2,
    INTERMIT = 2'd3
  } state_t;

  localparam int KILL_W  = 10;
  localparam int WAVE_W  = 4;
  localparam int TIMER_W = 8;

  localparam logic [KILL_W-1:0] KILL_MAX = 10'd999;

endpackage

// File: rtl/enemy_wave_scheduler_frame_timer.sv
// Loadable frame down-counter shared by the spawn gap and the intermission.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   load        - load value (takes priority over dec)
//   load_value  - value loaded when load is high
//   dec         - decrement request, normally a qualified frame tick
//   zero        - high while the count is zero
module frame_timer
  import enemy_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  // The count parks at zero instead of wrapping, so a stray decrement while
  // the owner waits on zero does not restart a long countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Enemy wave scheduler: releases enemy slots in staggered waves, arbitrates
// bullet collisions into one kill per cycle and reports score/wave to the HUD.
// Ports:
//   clk, reset          - pixel clock, synchronous active-high reset
//   frameTick           - one-cycle pulse per video frame
//   start               - begins play from IDLE (ignored elsewhere)
//   collisionFlag       - per-slot bullet overlap reports
//   enemyPresent        - per-slot enemy enables
//   collisionFeedback   - one-cycle kill acknowledge per slot
//   bulletHit           - one-cycle pulse retiring the bullet
//   killCount           - total kills, saturating at KILL_MAX
//   waveNum             - current wave, saturating at MAX_WAVE
//   waveClear           - one-cycle pulse when a wave is destroyed
module enemy_wave_scheduler
  import enemy_pkg::*;
#(
  parameter int NUM_ENEMIES  = 8,
  parameter int SPAWN_GAP    = 30,
  parameter int INTERMISSION = 120,
  parameter int MAX_WAVE     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frameTick,
  input  logic                   start,
  input  logic [NUM_ENEMIES-1:0] collisionFlag,
  output logic [NUM_ENEMIES-1:0] enemyPresent,
  output logic [NUM_ENEMIES-1:0] collisionFeedback,
  output logic                   bulletHit,
  output logic [KILL_W-1:0]      killCount,
  output logic [WAVE_W-1:0]      waveNum,
  output logic                   waveClear
);

  localparam int              PTR_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_ENEMIES - 1);

  state_t                   state, state_next;
  logic [PTR_W-1:0]         ptr, ptr_next;
  logic [NUM_ENEMIES-1:0]   present_next, feedback_next, grant;
  logic                     hit_next, clear_next;
  logic [KILL_W-1:0]        kills_next;
  logic [WAVE_W-1:0]        wave_next;
  logic                     timer_load, timer_dec, timer_zero;
  logic [TIMER_W-1:0]       timer_value;

  // Isolates the lowest set bit: adding one to the inverted vector carries
  // exactly up to the first one, so the AND keeps only that bit.
  function automatic logic [NUM_ENEMIES-1:0] lowest_one(input logic [NUM_ENEMIES-1:0] req);
    return req & (~req + 1'b1);
  endfunction

  // Only enemies currently on screen may be killed; this also masks a flag
  // that stays high after its kill.
  assign grant = lowest_one(collisionFlag & enemyPresent);

  frame_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      ptr               <= '0;
      enemyPresent      <= '0;
      collisionFeedback <= '0;
      bulletHit         <= 1'b0;
      killCount         <= '0;
      waveNum           <= '0;
      waveClear         <= 1'b0;
    end else begin
      state             <= state_next;
      ptr               <= ptr_next;
      enemyPresent      <= present_next;
      collisionFeedback <= feedback_next;
      bulletHit         <= hit_next;
      killCount         <= kills_next;
      waveNum           <= wave_next;
      waveClear         <= clear_next;
    end
  end

  // Release and kill are applied to the same next-present vector; they can
  // never touch the same slot because a release targets an empty slot and a
  // kill targets an occupied one.
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    present_next  = enemyPresent;
    feedback_next = '0;
    hit_next      = 1'b0;
    kills_next    = killCount;
    wave_next     = waveNum;
    clear_next    = 1'b0;
    timer_load    = 1'b0;
    timer_value   = '0;
    timer_dec     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = SPAWN;
          ptr_next   = '0;
          timer_load = 1'b1;
        end
      end

      SPAWN: begin
        if (frameTick) begin
          if (timer_zero) begin
            present_next[ptr] = 1'b1;
            ptr_next          = ptr + 1'b1;
            timer_load        = 1'b1;
            timer_value       = TIMER_W'(SPAWN_GAP - 1);
            if (ptr == LAST_SLOT) begin
              state_next = ACTIVE;
            end
          end else begin
            timer_dec = 1'b1;
          end
        end
      end

      // Clear is judged on the registered enables, so it fires the cycle
      // after the last kill lands.
      ACTIVE: begin
        if (enemyPresent == '0) begin
          clear_next  = 1'b1;
          state_next  = INTERMIT;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(INTERMISSION - 1);
        end
      end

      INTERMIT: begin
        if (frameTick) begin
          if (timer_zero) begin
            if (waveNum != WAVE_W'(MAX_WAVE)) begin
              wave_next = waveNum + 1'b1;
            end
            state_next = SPAWN;
            ptr_next   = '0;
            timer_load = 1'b1;
          end else begin
            timer_dec = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (((state == SPAWN) || (state == ACTIVE)) && (grant != '0)) begin
      present_next  = present_next & ~grant;
      feedback_next = grant;
      hit_next      = 1'b1;
      if (killCount != KILL_MAX) begin
        kills_next = killCount + 1'b1;
      end
    end
  end

endmodule

// File: doc/enemy_wave_scheduler.md
# enemy_wave_scheduler

Controller that sequences the bank of enemy instances in the game datapath. It owns every enemy's `enemyPresent` enable and releases enemies in staggered waves. It arbitrates their simultaneous `collisionFlag` reports into one kill per cycle and returns `collisionFeedback`, a bullet-retire pulse and score/wave counters to the HUD. It sits between the per-enemy instances and the bullet/score logic, clocked by the pixel clock.

## Interface
Parameters:
- `NUM_ENEMIES`, 8: enemy slots managed, 1–16.
- `SPAWN_GAP`, 30: frames between consecutive slot releases within a wave, 1–255.
- `INTERMISSION`, 120: frames between wave clear and next wave, 1–255.
- `MAX_WAVE`, 15: wave counter saturation value.

Ports:
- `clk`  in  1  pixel/system clock.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `frameTick`  in  1  one-cycle pulse per video frame.
- `start`  in  1  level or pulse; begins play from IDLE.
- `collisionFlag`  in  NUM_ENEMIES  per-slot bullet overlap, bit i from enemy i.
- `enemyPresent`  out  NUM_ENEMIES  per-slot enable to enemy i.
- `collisionFeedback`  out  NUM_ENEMIES  one-cycle kill acknowledge to slot i.
- `bulletHit`  out  1  one-cycle pulse; bullet logic retires bullet.
- `killCount`  out  10  total kills, saturates at 999.
- `waveNum`  out  4  current wave, 0 after reset.
- `waveClear`  out  1  one-cycle pulse when a wave is fully destroyed.

## Operation
- States: IDLE, SPAWN, ACTIVE, INTERMIT.
- IDLE: all outputs 0. `start`=1 → SPAWN, spawn pointer=0, frame timer=0.
- SPAWN: on each `frameTick` where timer==0, set `enemyPresent[ptr]`, increment ptr, reload timer=SPAWN_GAP-1; otherwise, on `frameTick`, decrement timer. First release occurs on the first `frameTick` after entering SPAWN. After slot NUM_ENEMIES-1 is released → ACTIVE.
- ACTIVE: no releases. When `enemyPresent`==0 → `waveClear` pulse, → INTERMIT, timer=INTERMISSION-1.
- INTERMIT: decrement timer on `frameTick`. On the tick with timer==0, `waveNum` increments (saturates at MAX_WAVE) → SPAWN, ptr=0, timer=0.
- Kill arbitration runs in SPAWN and ACTIVE:
  - Valid request = `collisionFlag & enemyPresent`.
  - Lowest-index valid slot i wins. Clear `enemyPresent[i]`, pulse `collisionFeedback[i]` and `bulletHit`, increment `killCount` (hold at 999).
  - Losing requests in the same cycle are dropped, because one bullet yields one kill.
- If all released slots are killed while still in SPAWN, stay in SPAWN. Clear detection applies only in ACTIVE.
- `start` outside IDLE is ignored. There is no return to IDLE except `reset`.

## Timing
- All outputs are registered. Reset value of every output is 0, state=IDLE, ptr=0, timer=0.
- Kill latency: `collisionFlag[i]` sampled at edge k. At edge k+1 `enemyPresent[i]`=0 and `collisionFeedback[i]`=`bulletHit`=1 for exactly one cycle. `killCount` updates on the same edge.
- A held `collisionFlag[i]` after the kill is masked by `enemyPresent[i]`=0, so there is no double count.
- Release: `enemyPresent[ptr]` rises on the edge that samples the qualifying `frameTick`.
- Simultaneous release and kill in one cycle: both apply. They target different slots by construction, because release only targets unset slot ptr and a kill only targets a set slot.
- `waveClear` is asserted on the edge after `enemyPresent` is observed all-zero in ACTIVE.
- `reset` mid-wave: next edge clears everything; `killCount` and `waveNum` return to 0.

## Structure
- Shared package `enemy_pkg`:
  - state enum (IDLE=0, SPAWN=1, ACTIVE=2, INTERMIT=3).
  - KILL_MAX=999, counter widths.
- Sub-module `frame_timer`: 8-bit loadable down-counter, decremented on `frameTick`, with `zero` flag. It is shared by SPAWN and INTERMIT.
- Priority arbiter: a function or generate loop inside the top module; no separate module.

## Test plan
- Reset then `start` with NUM_ENEMIES=4, SPAWN_GAP=2 → `enemyPresent` = 0001, 0011, 0111, 1111 on frame ticks 1, 3, 5, 7; state ACTIVE after the 4th release.
- `collisionFlag`=0110 held 3 cycles in ACTIVE → cycle+1: present 1101, feedback 0010, `bulletHit`=1; cycle+2: present 1001, feedback 0100; `killCount`=2.
- Kill all 4 → `waveClear` pulse one cycle after last kill. INTERMISSION=3 → `waveNum`=1 and SPAWN restart on the 3rd subsequent frame tick.
- `collisionFlag`=1111 while `enemyPresent`=0000 → no feedback, `killCount` unchanged.
- Preload `killCount` to 999 via 999 kills (or force), one more kill → `killCount` stays 999, feedback still pulses.
- Assert `reset` mid-SPAWN with present=0011 → next edge all outputs 0, IDLE; `start` ignored while `reset` high.
